// File: rtl/pc_unit.sv
// Registered fetch program counter with trap/stall/jump arbitration and a redirect pulse.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_unit #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         PC_INC       = 4,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_stall,
  input  logic                cpu_stall,
  input  logic                enable_jump,
  input  logic                pc_jump_control,
  input  logic [PC_WIDTH-1:0] pc_jump_address,
  input  logic                trap_valid,
  input  logic [PC_WIDTH-1:0] trap_vector,
  input  logic                call_push,
  input  logic [PC_WIDTH-1:0] call_ret_addr,
  input  logic                ret_pop,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_valid,
  output logic                redirect,
  output logic [PC_WIDTH-1:0] ret_target,
  output logic                ret_valid
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                redirect_q, redirect_d;
  logic                stall;

  assign stall = pc_stall | cpu_stall;

  always_comb begin
    pc_d          = pc_q + PC_WIDTH'(PC_INC);
    redirect_d    = 1'b0;
    fetch_valid_d = 1'b1;
    if (trap_valid) begin
      pc_d       = {trap_vector[PC_WIDTH-1:2], 2'b00};
      redirect_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (enable_jump && pc_jump_control) begin
      pc_d       = {pc_jump_address[PC_WIDTH-1:2], 2'b00};
      redirect_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      redirect_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      redirect_q    <= redirect_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign redirect    = redirect_q;

`ifdef PC_RAS_EN
  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                do_push, do_pop;
  logic [1:0]          unused_ras;

  assign do_push = call_push & ~stall;
  assign do_pop  = ret_pop & (cnt_q != '0);

  // ptr_q addresses the top entry; power-of-2 depth makes the pointer wrap naturally
  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (do_push && do_pop) begin
      ras_d[ptr_q] = call_ret_addr;
    end else if (do_push) begin
      ptr_d        = ptr_q + 1'b1;
      ras_d[ptr_d] = call_ret_addr;
      if (cnt_q != CntW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (do_pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ret_valid  = (cnt_q != '0);
  assign ret_target = ret_valid ? ras_q[ptr_q] : '0;
  assign unused_ras = trap_vector[1:0] ^ pc_jump_address[1:0];
`else
  logic unused_ras;

  assign ret_target = '0;
  assign ret_valid  = 1'b0;
  assign unused_ras = ^{call_push, ret_pop, call_ret_addr, trap_vector[1:0],
                        pc_jump_address[1:0]};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a reference model queues expected state per edge,
// compared one edge later. RAS cases run when PC_RAS_EN is defined.
module tb_pc_unit;

  localparam int unsigned W     = 32;
  localparam int unsigned Depth = 4;

  typedef struct packed {
    logic [W-1:0] pc;
    logic         fv;
    logic         redir;
    logic         rv;
    logic [W-1:0] rt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         pc_stall, cpu_stall, enable_jump, pc_jump_control;
  logic [W-1:0] pc_jump_address, trap_vector, call_ret_addr;
  logic         trap_valid, call_push, ret_pop;
  logic [W-1:0] pc, ret_target;
  logic         fetch_valid, redirect, ret_valid;

  int checks   = 0;
  int failures = 0;

  exp_t         sb_q[$];
  logic [W-1:0] m_ras[$];
  logic [W-1:0] m_pc;
  logic         m_fv, m_red;

  always #5 clk = ~clk;

  pc_unit #(
    .PC_WIDTH    (W),
    .RESET_VECTOR(32'h0000_0000),
    .PC_INC      (4),
    .RAS_DEPTH   (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_stall       (pc_stall),
    .cpu_stall      (cpu_stall),
    .enable_jump    (enable_jump),
    .pc_jump_control(pc_jump_control),
    .pc_jump_address(pc_jump_address),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .call_push      (call_push),
    .call_ret_addr  (call_ret_addr),
    .ret_pop        (ret_pop),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .redirect       (redirect),
    .ret_target     (ret_target),
    .ret_valid      (ret_valid)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pc_stall        = 1'b0;
    cpu_stall       = 1'b0;
    enable_jump     = 1'b0;
    pc_jump_control = 1'b0;
    pc_jump_address = '0;
    trap_valid      = 1'b0;
    trap_vector     = '0;
    call_push       = 1'b0;
    call_ret_addr   = '0;
    ret_pop         = 1'b0;
  endtask

  // Model the next edge from the current inputs, then compare after the edge.
  task automatic step(input string tag);
    exp_t e;
    logic st, push_ok, pop_ok;
    st = pc_stall | cpu_stall;
    if (rst) begin
      m_pc  = '0;
      m_fv  = 1'b0;
      m_red = 1'b0;
      m_ras.delete();
    end else begin
      m_fv = 1'b1;
      if (trap_valid) begin
        m_pc  = trap_vector & ~32'h3;
        m_red = 1'b1;
      end else if (st) begin
        m_red = 1'b0;
      end else if (enable_jump && pc_jump_control) begin
        m_pc  = pc_jump_address & ~32'h3;
        m_red = 1'b1;
      end else begin
        m_pc  = m_pc + 32'd4;
        m_red = 1'b0;
      end
`ifdef PC_RAS_EN
      push_ok = call_push & ~st;
      pop_ok  = ret_pop & (m_ras.size() != 0);
      if (push_ok && pop_ok) begin
        m_ras[m_ras.size()-1] = call_ret_addr;
      end else if (push_ok) begin
        if (m_ras.size() == Depth) void'(m_ras.pop_front());
        m_ras.push_back(call_ret_addr);
      end else if (pop_ok) begin
        void'(m_ras.pop_back());
      end
`else
      push_ok = 1'b0;
      pop_ok  = 1'b0;
`endif
    end
    e.pc    = m_pc;
    e.fv    = m_fv;
    e.redir = m_red;
    e.rv    = (m_ras.size() != 0);
    e.rt    = e.rv ? m_ras[$] : '0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".pc"}, pc, e.pc);
    check({tag, ".fetch_valid"}, W'(fetch_valid), W'(e.fv));
    check({tag, ".redirect"}, W'(redirect), W'(e.redir));
    check({tag, ".ret_valid"}, W'(ret_valid), W'(e.rv));
    check({tag, ".ret_target"}, ret_target, e.rt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    step("rst0");
    step("rst1");
    check("rst_pc_const", pc, 32'h0);
    rst = 1'b0;
    step("rel0");
    check("rel0_pc_const", pc, 32'h4);
    step("rel1");
    check("rel1_pc_const", pc, 32'h8);

    enable_jump = 1'b1; pc_jump_control = 1'b1; pc_jump_address = 32'h1003;
    step("jump");
    check("jump_pc_const", pc, 32'h1000);
    idle();
    step("post_jump");
    enable_jump = 1'b1;
    step("jump_not_taken");
    pc_jump_control = 1'b1; pc_jump_address = 32'h20;
    step("jump_20");
    pc_jump_address = 32'h500; pc_stall = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i));
    check("stall_pc_const", pc, 32'h20);
    idle();
    step("unstall");

    cpu_stall = 1'b1; trap_valid = 1'b1; trap_vector = 32'h80;
    step("trap_over_stall");
    check("trap_pc_const", pc, 32'h80);
    cpu_stall = 1'b0; trap_vector = 32'h1C2;
    step("trap_again");
    idle();
    step("after_trap");

    enable_jump = 1'b1; pc_jump_control = 1'b1; pc_jump_address = 32'hFFFF_FFFE;
    step("jump_top");
    idle();
    step("wrap");
    check("wrap_pc_const", pc, 32'h0);

    for (int i = 1; i <= 5; i++) begin
      call_push = 1'b1; call_ret_addr = 32'(i * 16);
      step($sformatf("push%0d", i));
    end
    idle();
`ifdef PC_RAS_EN
    check("ras_full_top", ret_target, 32'h50);
`endif
    ret_pop = 1'b1;
    for (int i = 1; i <= 5; i++) step($sformatf("pop%0d", i));
    idle();
    call_push = 1'b1; call_ret_addr = 32'h99; pc_stall = 1'b1;
    step("push_stalled");
    pc_stall = 1'b0; ret_pop = 1'b1; call_ret_addr = 32'h100;
    step("pushpop_empty");
    call_ret_addr = 32'h200;
    step("pushpop_replace");
    ret_pop = 1'b0; call_ret_addr = 32'h300; trap_valid = 1'b1; trap_vector = 32'h40;
    step("push_with_trap");

    rst = 1'b1; enable_jump = 1'b1; pc_jump_control = 1'b1; pc_jump_address = 32'h700;
    step("midrst");
    rst = 1'b0;
    idle();
    step("midrst_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
